// File: rtl/rtc_bus_scheduler.sv
// RTC register bus scheduler: arbitrates scanner reads vs. user writes.
// Define RTC_WR_PRIORITY_EN to make writes win every tie (no round-robin).
module rtc_bus_scheduler #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              wr_done,
    output logic              bus_start,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_done,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        RECOVER
    } state_t;

    state_t            state, state_d;
    logic [TO_W-1:0]   cnt, cnt_d;
    logic              last_wr, last_wr_d;
    logic              sel_rd, sel_wr;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, rdata_d;
    logic              rw_d, start_d, rgnt_d, wgnt_d;
    logic              rdone_d, wdone_d, err_d, busy_d;

    always_comb begin
        sel_rd = 1'b0;
        sel_wr = 1'b0;
        if (rd_req && wr_req) begin
`ifdef RTC_WR_PRIORITY_EN
            sel_wr = 1'b1;
`else
            sel_rd = last_wr;
            sel_wr = !last_wr;
`endif
        end else begin
            sel_rd = rd_req;
            sel_wr = wr_req;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        last_wr_d = last_wr;
        addr_d    = bus_addr;
        wdata_d   = bus_wdata;
        rw_d      = bus_rw;
        rdata_d   = rd_data;
        start_d   = 1'b0;
        rgnt_d    = 1'b0;
        wgnt_d    = 1'b0;
        rdone_d   = 1'b0;
        wdone_d   = 1'b0;
        err_d     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_rd || sel_wr) begin
                    state_d   = ISSUE;
                    rw_d      = sel_rd;
                    addr_d    = sel_rd ? rd_addr : wr_addr;
                    wdata_d   = sel_wr ? wr_data : bus_wdata;
                    last_wr_d = sel_wr;
                    start_d   = 1'b1;
                    rgnt_d    = sel_rd;
                    wgnt_d    = sel_wr;
                    cnt_d     = '0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt + 1'b1;
                // A completion on the timeout cycle still counts as success
                if (bus_done) begin
                    state_d = DONE;
                    rdone_d = bus_rw;
                    wdone_d = !bus_rw;
                    if (bus_rw)
                        rdata_d = bus_rdata;
                end else if (cnt == TO_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    rdone_d = bus_rw;
                    wdone_d = !bus_rw;
                    err_d   = 1'b1;
                end
            end
            DONE:    state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_wr     <= 1'b1;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_rw      <= 1'b0;
            rd_data     <= '0;
            bus_start   <= 1'b0;
            rd_gnt      <= 1'b0;
            wr_gnt      <= 1'b0;
            rd_done     <= 1'b0;
            wr_done     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            last_wr     <= last_wr_d;
            bus_addr    <= addr_d;
            bus_wdata   <= wdata_d;
            bus_rw      <= rw_d;
            rd_data     <= rdata_d;
            bus_start   <= start_d;
            rd_gnt      <= rgnt_d;
            wr_gnt      <= wgnt_d;
            rd_done     <= rdone_d;
            wr_done     <= wdone_d;
            timeout_err <= err_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Scoreboard bench for rtc_bus_scheduler: directed transactions,
// expected gnt/done events queued and checked by a negedge monitor.
module tb_rtc_bus_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rd_req = 1'b0;
    logic [7:0] rd_addr = '0;
    logic       rd_gnt, rd_done;
    logic [7:0] rd_data;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_gnt, wr_done;
    logic       bus_start, bus_rw;
    logic [7:0] bus_addr, bus_wdata;
    logic [7:0] bus_rdata = '0;
    logic       bus_done = 1'b0;
    logic       busy, timeout_err;

    rtc_bus_scheduler dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_done(rd_done), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_gnt(wr_gnt), .wr_done(wr_done),
        .bus_start(bus_start), .bus_rw(bus_rw), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_done(bus_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 rd_gnt, 1 wr_gnt, 2 rd_done, 3 wr_done
    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] a;
        logic [7:0] d;
        logic       rw;
        logic       err;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_rd = '0;
    int         mk;
    exp_t       me;

    always @(negedge clk) begin
        if (rd_gnt || wr_gnt || rd_done || wr_done || timeout_err) begin
            mk = rd_gnt ? 0 : wr_gnt ? 1 : rd_done ? 2 : wr_done ? 3 : 4;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event kind=%0d cyc=%0d required none",
                         mk, cyc);
            end else begin
                me = q.pop_front();
                if (mk != me.kind || cyc != me.cyc) begin
                    n_bad++;
                    $display("FAIL event got kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                             mk, cyc, me.kind, me.cyc);
                end
                n_cmp++;
                if (mk < 2) begin
                    if (!bus_start || bus_rw != me.rw || bus_addr != me.a ||
                        (!me.rw && bus_wdata != me.d) || !busy) begin
                        n_bad++;
                        $display("FAIL grant_bus got start=%b rw=%b addr=%h wdata=%h busy=%b required start=1 rw=%b addr=%h wdata=%h busy=1",
                                 bus_start, bus_rw, bus_addr, bus_wdata, busy,
                                 me.rw, me.a, me.d);
                    end
                end else begin
                    if (timeout_err != me.err || rd_data != me.d || bus_start) begin
                        n_bad++;
                        $display("FAIL done_status got err=%b rd_data=%h start=%b required err=%b rd_data=%h start=0",
                                 timeout_err, rd_data, bus_start, me.err, me.d);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input int c, input logic [7:0] a,
                        input logic [7:0] d, input logic rw, input logic err);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        e.a    = a;
        e.d    = d;
        e.rw   = rw;
        e.err  = err;
        q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        logic [41:0] v;
        v = {rd_gnt, rd_done, rd_data, wr_gnt, wr_done, bus_start, bus_rw,
             bus_addr, bus_wdata, busy, timeout_err};
        n_cmp++;
        if (v != '0) begin
            n_bad++;
            $display("FAIL %s outputs got %h required 0", name, v);
        end
    endtask

    // done_at: WAIT cycle index carrying bus_done (0 = never, forces timeout)
    task automatic txn(input logic rw, input logic [7:0] a, input logic [7:0] wd,
                       input int done_at, input logic [7:0] rdat, input bit drop);
        int n;
        int w;
        step();
        n = cyc;
        if (rw) begin
            rd_req  = 1'b1;
            rd_addr = a;
        end else begin
            wr_req  = 1'b1;
            wr_addr = a;
            wr_data = wd;
        end
        w = (done_at > 0) ? done_at : 256;
        push(rw ? 0 : 1, n + 1, a, wd, rw, 1'b0);
        if (rw && done_at > 0)
            exp_rd = rdat;
        push(rw ? 2 : 3, n + 2 + w, 8'h00, exp_rd, 1'b0, done_at == 0);
        step();
        if (drop) begin
            rd_req = 1'b0;
            wr_req = 1'b0;
        end
        repeat (w) step();
        if (done_at > 0) begin
            bus_done  = 1'b1;
            bus_rdata = rdat;
        end
        step();
        bus_done  = 1'b0;
        bus_rdata = 8'h00;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        step();
    endtask

    task automatic contention();
        int  n;
        int  b;
        logic r;
        step();
        n       = cyc;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        rd_addr = 8'h10;
        wr_addr = 8'h50;
        wr_data = 8'hA5;
        for (int t = 0; t < 4; t++) begin
            b = n + 5 * t;
`ifdef RTC_WR_PRIORITY_EN
            r = 1'b0;
`else
            r = (t % 2 == 0);
`endif
            push(r ? 0 : 1, b + 1, r ? 8'h10 : 8'h50, 8'hA5, r, 1'b0);
            if (r)
                exp_rd = 8'h60 + 8'(t);
            push(r ? 2 : 3, b + 3, 8'h00, exp_rd, 1'b0, 1'b0);
        end
        for (int t = 0; t < 4; t++) begin
            step();
            step();
            bus_done  = 1'b1;
            bus_rdata = 8'h60 + 8'(t);
            step();
            bus_done  = 1'b0;
            bus_rdata = 8'h00;
            if (t == 3) begin
                rd_req = 1'b0;
                wr_req = 1'b0;
            end
            step();
            step();
        end
    endtask

    initial begin
        int n;
        @(negedge clk);
        check_zero("reset_state");
        step();
        reset = 1'b1;

        contention();
        txn(1'b1, 8'h21, 8'h00, 3, 8'h59, 1'b0);
        txn(1'b0, 8'h22, 8'h30, 1, 8'hEE, 1'b1);
        txn(1'b1, 8'h41, 8'h00, 0, 8'hEE, 1'b0);
        txn(1'b1, 8'h41, 8'h00, 256, 8'h7C, 1'b0);

        step();
        n       = cyc;
        wr_req  = 1'b1;
        wr_addr = 8'h33;
        wr_data = 8'h44;
        push(1, n + 1, 8'h33, 8'h44, 1'b0, 1'b0);
        repeat (3) step();
        reset  = 1'b0;
        wr_req = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        check_zero("reset_mid_wait");
        exp_rd = 8'h00;
        txn(1'b1, 8'h12, 8'h00, 2, 8'h9A, 1'b0);

        repeat (8) step();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events got %0d required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
